regfile_param: RTL and testbench
================================

# regfile_param

Parametrised multi-port register file for the MIPS datapath. It generalises the fixed 16-entry, 32-bit, 16:1 read-select path into a configurable WIDTH x DEPTH storage array with two read ports, one write port, and write-through bypass. An optional registered-output mode with per-port hold supports pipelined decode stages. It sits between the decode stage (register addresses) and the ALU operand muxes (read data), with writeback driving the write port.

## Interface
- WIDTH, 32, data width in bits (>= 1)
- DEPTH, 16, number of registers; power of two, >= 2
- AW, 4, address width; must equal log2(DEPTH)
- ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are discarded
- REG_OUT, 0, 0 = combinational read ports; 1 = read data registered on clk

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- regWrite  input  1  write enable, sampled on rising clk
- writeReg  input  AW  write address
- writeData  input  WIDTH  write data
- readReg1  input  AW  read port 1 address
- readReg2  input  AW  read port 2 address
- readHold1  input  1  REG_OUT=1 only: 1 = port 1 output register keeps its value; ignored when REG_OUT=0
- readHold2  input  1  as readHold1, for port 2
- readData1  output  WIDTH  read port 1 data
- readData2  output  WIDTH  read port 2 data

## Operation
- Storage: DEPTH registers of WIDTH bits.
- rst_n low, asynchronously: all registers clear to 0. In REG_OUT=1 mode, both output registers also clear to 0. Reset is held while rst_n is low. Normal operation resumes at the first rising clk after deassertion.
- Write: on rising clk with rst_n high and regWrite=1, reg[writeReg] <= writeData.
  - If ZERO_REG=1 and writeReg=0, the write is dropped.
- Read-select value for port n:
  - If ZERO_REG=1 and readRegn=0: the value is 0.
  - Else, if regWrite=1 and writeReg=readRegn: the value is writeData (write-through bypass).
  - Else: the value is reg[readRegn].
- REG_OUT=0: readDatan equals the read-select value combinationally.
- REG_OUT=1:
  - On rising clk with readHoldn=0, readDatan <= read-select value.
  - On rising clk with readHoldn=1, readDatan holds its value. The hold does not block writes to the array.
- Both ports may address the same register. Both then return identical data, including bypassed data.
- Addresses >= DEPTH cannot occur because AW = log2(DEPTH).
- There is no X propagation: every register and output is defined from reset.

## Timing
- Write latency: data written at edge k is readable from reg[] after edge k. With bypass, the same-cycle read before edge k already returns writeData.
- REG_OUT=0: read latency is 0 cycles (combinational from readRegn, regWrite, writeReg, writeData).
- REG_OUT=1: read latency is 1 cycle. Address presented in cycle k appears on readDatan after edge k. A bypassed write in cycle k also appears after edge k.
- Simultaneous write and hold on the same address (REG_OUT=1): the output keeps the old value. A later unheld read returns the new value.
- Reset asserted mid-cycle forces outputs (REG_OUT=1) and array to 0 immediately, without waiting for clk. A write in flight at that edge is lost.

## Test plan
- Reset: write 0xDEADBEEF to reg 5, assert rst_n=0 mid-cycle -> readData1 = 0 for readReg1=5, immediately in REG_OUT=0. In REG_OUT=1, outputs read 0 asynchronously.
- Write/read all: write reg[i]=0x1000_0000+i for i=1..15, then read pairs (i, 15-i) -> exact values on both ports. In REG_OUT=1 the values appear one cycle late.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 -> readData1 = readData2 = 0. With ZERO_REG=0, the same write reads back 0xFFFFFFFF.
- Bypass: regWrite=1, writeReg=7, writeData=0xA5A5A5A5, readReg1=readReg2=7 in the same cycle -> both ports show 0xA5A5A5A5 before the edge (REG_OUT=0) or right after it (REG_OUT=1).
- Hold (REG_OUT=1): port 1 shows reg3=0x11; set readHold1=1, write reg3=0x22, change readReg1=4 -> readData1 stays 0x11 while port 2 tracks normally. Release hold -> readData1 updates to reg4 on the next edge.
- Parameter sweep: WIDTH=8/DEPTH=4 and WIDTH=64/DEPTH=32 -> random write/read sequence matches a reference model, including bypass and zero-register rules.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: WIDTH x DEPTH register file with two read ports and one write
// port. A read of the address being written in the same cycle returns the
// write data. The read ports are either combinational or registered, and a
// registered port can be held per port.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1,
  parameter int REG_OUT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             regWrite,
  input  logic [AW-1:0]    writeReg,
  input  logic [WIDTH-1:0] writeData,
  input  logic [AW-1:0]    readReg1,
  input  logic [AW-1:0]    readReg2,
  input  logic             readHold1,
  input  logic             readHold2,
  output logic [WIDTH-1:0] readData1,
  output logic [WIDTH-1:0] readData2
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [WIDTH-1:0] sel1;
  logic [WIDTH-1:0] sel2;

  // With ZERO_REG set, register 0 stays at zero, so a write to it is dropped.
  assign wr_en = regWrite && !(ZR && (writeReg == '0));

  // Storage array. The asynchronous reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[writeReg] <= writeData;
    end
  end

  // Read select for port 1. The zero register overrides bypass, and bypass overrides the array.
  always_comb begin
    sel1 = mem[readReg1];
    if (regWrite && (writeReg == readReg1)) sel1 = writeData;
    if (ZR && (readReg1 == '0)) sel1 = '0;
  end

  // Read select for port 2. It uses the same priority as port 1.
  always_comb begin
    sel2 = mem[readReg2];
    if (regWrite && (writeReg == readReg2)) sel2 = writeData;
    if (ZR && (readReg2 == '0)) sel2 = '0;
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      // Registered read ports. A hold freezes only its own output; array writes still happen.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          readData1 <= '0;
          readData2 <= '0;
        end else begin
          if (!readHold1) readData1 <= sel1;
          if (!readHold2) readData2 <= sel2;
        end
      end
    end else begin : g_comb_out
      // In combinational mode the hold inputs have no function.
      logic unused_hold;
      assign unused_hold = readHold1 ^ readHold2;
      assign readData1   = sel1;
      assign readData2   = sel2;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param. One stimulus stream drives three instances:
// - 32x16, zero register, combinational read ports
// - 32x16, zero register, registered read ports
// - 8x4, no zero register, combinational read ports
// The outputs are compared against array models kept in the bench.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regWrite;
  logic [3:0]  writeReg;
  logic [31:0] writeData;
  logic [3:0]  readReg1, readReg2;
  logic        readHold1, readHold2;
  logic [31:0] rd1_c, rd2_c, rd1_r, rd2_r;
  logic [7:0]  rd1_s, rd2_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(32), .DEPTH(16), .AW(4), .ZERO_REG(1), .REG_OUT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readHold1(readHold1), .readHold2(readHold2),
    .readData1(rd1_c), .readData2(rd2_c));

  regfile_param #(.WIDTH(32), .DEPTH(16), .AW(4), .ZERO_REG(1), .REG_OUT(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readHold1(readHold1), .readHold2(readHold2),
    .readData1(rd1_r), .readData2(rd2_r));

  regfile_param #(.WIDTH(8), .DEPTH(4), .AW(2), .ZERO_REG(0), .REG_OUT(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeReg(writeReg[1:0]),
    .writeData(writeData[7:0]), .readReg1(readReg1[1:0]), .readReg2(readReg2[1:0]),
    .readHold1(readHold1), .readHold2(readHold2),
    .readData1(rd1_s), .readData2(rd2_s));

  // Reference state.
  logic [31:0] m16 [16];
  logic [7:0]  m4  [4];
  logic [31:0] exp_r1, exp_r2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sel16(input logic [3:0] a);
    if (a == 4'd0) return 32'd0;
    if (regWrite && writeReg == a) return writeData;
    return m16[a];
  endfunction

  function automatic logic [7:0] sel4(input logic [1:0] a);
    if (regWrite && writeReg[1:0] == a) return writeData[7:0];
    return m4[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m16[i] = '0;
    for (int i = 0; i < 4; i++) m4[i] = '0;
    exp_r1 = '0;
    exp_r2 = '0;
  endtask

  // Model update for one rising edge. Both read selects use the array as it is before the write.
  task automatic model_edge();
    if (!readHold1) exp_r1 = sel16(readReg1);
    if (!readHold2) exp_r2 = sel16(readReg2);
    if (regWrite) begin
      if (writeReg != 4'd0) m16[writeReg] = writeData;
      m4[writeReg[1:0]] = writeData[7:0];
    end
  endtask

  task automatic check_all();
    chk("c_rd1", {32'd0, rd1_c}, {32'd0, sel16(readReg1)});
    chk("c_rd2", {32'd0, rd2_c}, {32'd0, sel16(readReg2)});
    chk("r_rd1", {32'd0, rd1_r}, {32'd0, exp_r1});
    chk("r_rd2", {32'd0, rd2_r}, {32'd0, exp_r2});
    chk("s_rd1", {56'd0, rd1_s}, {56'd0, sel4(readReg1[1:0])});
    chk("s_rd2", {56'd0, rd2_s}, {56'd0, sel4(readReg2[1:0])});
  endtask

  // One cycle: check at the falling edge, update the model at the rising edge, then leave 1 time unit for new inputs.
  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic h1, input logic h2);
    regWrite  = we;  writeReg  = wa;  writeData = wd;
    readReg1  = ra1; readReg2  = ra2;
    readHold1 = h1;  readHold2 = h2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // Asynchronous reset asserted mid-cycle.
    drive(1'b1, 4'd5, 32'hDEADBEEF, 4'd5, 4'd5, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 4'd0, 32'd0, 4'd5, 4'd5, 1'b0, 1'b0);
    cyc();
    chk("pre_rst_c", {32'd0, rd1_c}, 64'hDEADBEEF);
    chk("pre_rst_r", {32'd0, rd1_r}, 64'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_async_c", {32'd0, rd1_c}, 64'd0);
    chk("rst_async_r", {32'd0, rd1_r}, 64'd0);
    chk("rst_async_r2", {32'd0, rd2_r}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // Write registers 1..15, then read them back in pairs.
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, 4'(i), 32'h1000_0000 + 32'(i), 4'(i), 4'(15 - i), 1'b0, 1'b0);
      cyc();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 32'd0, 4'(i), 4'(15 - i), 1'b0, 1'b0);
      cyc();
    end
    chk("wr_all_r1", {32'd0, rd1_r}, 64'h1000_000F);
    chk("wr_all_r2", {32'd0, rd2_r}, 64'd0);

    // Write to register 0: dropped where the zero register is enabled, kept in the 8x4 instance.
    drive(1'b1, 4'd0, 32'hFFFF_FFFF, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc();
    chk("zero_c1", {32'd0, rd1_c}, 64'd0);
    chk("zero_c2", {32'd0, rd2_c}, 64'd0);
    chk("zero_s1", {56'd0, rd1_s}, 64'hFF);

    // Write-through bypass on both ports.
    drive(1'b1, 4'd7, 32'hA5A5_A5A5, 4'd7, 4'd7, 1'b0, 1'b0);
    #1;
    chk("byp_c1", {32'd0, rd1_c}, 64'hA5A5_A5A5);
    chk("byp_c2", {32'd0, rd2_c}, 64'hA5A5_A5A5);
    cyc();
    chk("byp_r1", {32'd0, rd1_r}, 64'hA5A5_A5A5);
    chk("byp_r2", {32'd0, rd2_r}, 64'hA5A5_A5A5);

    // Port 1 hold while register 3 is rewritten and the port 1 address changes.
    drive(1'b1, 4'd3, 32'h11, 4'd3, 4'd3, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 4'd4, 32'h44, 4'd3, 4'd3, 1'b0, 1'b0);
    cyc();
    chk("hold_pre", {32'd0, rd1_r}, 64'h11);
    drive(1'b1, 4'd3, 32'h22, 4'd4, 4'd3, 1'b1, 1'b0);
    cyc();
    chk("hold_keep", {32'd0, rd1_r}, 64'h11);
    chk("hold_p2", {32'd0, rd2_r}, 64'h22);
    drive(1'b0, 4'd0, 32'd0, 4'd4, 4'd3, 1'b0, 1'b0);
    cyc();
    chk("hold_rel", {32'd0, rd1_r}, 64'h44);

    // Random traffic. Reads often target the write address to exercise bypass.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), wa, $urandom(),
            ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
